fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4; entry count, power of two, 2..16.
REQ-002 The block SHALL have parameter BYPASS, default 0; 1 lets an empty queue pass input to output in the same cycle.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port flush  input  1  redirect; discard all entries.
REQ-006 The block SHALL have port in_valid  input  1  producer (fetch) offers an entry.
REQ-007 The block SHALL have port in_data  input  fetch_data_t  {raw_instr, pc, valid} from fetch.
REQ-008 The block SHALL have port in_ready  output  1  queue accepts in_data this cycle.
REQ-009 The block SHALL have port out_valid  output  1  head entry available to decode.
REQ-010 The block SHALL have port out_data  output  fetch_data_t  head entry.
REQ-011 The block SHALL have port out_ready  input  1  consumer (decode) takes head this cycle.
REQ-012 The block SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-013 The block SHALL push when in_valid && in_ready, and pop when out_valid && out_ready.
REQ-014 The block SHALL drive in_ready = !flush && (count < DEPTH); no push into a full queue even if a pop occurs that cycle.
REQ-015 The block SHALL drive out_valid = !flush && (count != 0) when BYPASS=0.
REQ-016 When BYPASS=1, count==0 and in_valid, the block SHALL assert out_valid with out_data = in_data; if out_ready, the entry is consumed and not written.
REQ-017 With BYPASS=0, an entry pushed in cycle N SHALL first appear at out_data in cycle N+1.
REQ-018 The block SHALL implement storage as a circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 without an explicit compare.
REQ-019 For a simultaneous push and pop with 0 < count < DEPTH, count SHALL be unchanged and both pointers SHALL advance.
REQ-020 The block SHALL keep out_data stable while out_valid && !out_ready.
REQ-021 The block SHALL drive out_data as all-zero whenever out_valid=0.
REQ-022 Entries SHALL be delivered in push order, stored bit-exact including in_data.valid.
REQ-023 flush SHALL have priority over push and pop: in the flush cycle, in_ready=0 and out_valid=0, and in the next cycle count=0 with pointers equal.
REQ-024 flush and reset asserted together SHALL yield the reset state.
REQ-025 count SHALL never exceed DEPTH and never underflow; a pop request while empty (non-bypass) is ignored.

Reset
REQ-026 On a clk edge with reset=1, head=0, tail=0 and count=0 SHALL be set, and in the following cycle out_valid=0, out_data=0 and in_ready=1.
REQ-027 Reset asserted mid-operation SHALL discard all entries with no entry emitted after the reset edge.
REQ-028 Storage array contents SHALL not require reset.

Structure
REQ-029 Package pipes SHALL hold fetch_data_t (unchanged) and a new constant FQ_DEPTH = 4 used as the core-level default for DEPTH.
REQ-030 The block SHALL implement storage, pointers and count in one module with no sub-module.
REQ-031 The block SHALL contain no combinational path from out_ready to in_ready.

Verification
REQ-032 The bench SHALL cover: DEPTH=4, push pc 0x80000000,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0, out_data.pc=0x80000000 held.
REQ-033 The bench SHALL cover: full queue, out_ready=1 for 4 cycles, in_valid=0 -> pcs emerge 0x80000000..0x0C in order, then count=0, out_valid=0.
REQ-034 The bench SHALL cover: count=2, push and pop in the same cycle for 10 cycles -> count stays 2, and pointers wrap at least twice with order preserved.
REQ-035 The bench SHALL cover: count=3, flush=1 with in_valid=1 -> in_ready=0 and out_valid=0 that cycle, then count=0 next cycle, and the pushed entry never appears.
REQ-036 The bench SHALL cover: BYPASS=1, empty, in_valid=1 with pc 0x80000010 and out_ready=1 -> out_data.pc=0x80000010 in the same cycle, with count remaining 0.
REQ-037 The bench SHALL cover: reset=1 while count=3 -> the next cycle has count=0, out_valid=0, out_data=0 and in_ready=1.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared pipeline payload types and core-level sizing constants.
package pipes;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned FQ_DEPTH = 4;

    typedef struct packed {
        logic [XLEN-1:0] raw_instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } fetch_data_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: circular buffer with flush and optional empty bypass.
module fetch_queue
    import pipes::*;
#(
    parameter int unsigned DEPTH  = FQ_DEPTH,
    parameter bit          BYPASS = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  fetch_data_t                in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output fetch_data_t                out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    fetch_data_t   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;

    logic empty_c;
    logic byp_c;
    logic push_c;
    logic pop_c;

    // Handshake decode; in_ready depends only on flush and occupancy.
    always_comb begin
        empty_c   = (count == '0);
        byp_c     = BYPASS && empty_c && in_valid;
        in_ready  = !flush && (count < CW'(DEPTH));
        out_valid = !flush && (!empty_c || byp_c);
        out_data  = '0;
        if (out_valid) begin
            out_data = empty_c ? in_data : mem[head];
        end
        // A bypassed entry taken by decode never lands in storage.
        push_c = in_valid && in_ready && !(byp_c && out_ready);
        pop_c  = out_valid && out_ready && !empty_c;
    end

    // Pointers wrap naturally through their power-of-two width.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_c) tail <= tail + PW'(1);
            if (pop_c)  head <= head + PW'(1);
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage holds no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, BYPASS=0 and BYPASS=1 instances).
module tb_fetch_queue;
    import pipes::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    fetch_data_t in_data;
    logic        in_ready;
    logic        out_valid;
    fetch_data_t out_data;
    logic        out_ready;
    logic [2:0]  count;

    logic        bp_flush;
    logic        bp_in_valid;
    fetch_data_t bp_in_data;
    logic        bp_in_ready;
    logic        bp_out_valid;
    fetch_data_t bp_out_data;
    logic        bp_out_ready;
    logic [2:0]  bp_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .BYPASS(1'b0)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    fetch_queue #(.DEPTH(4), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .reset(reset), .flush(bp_flush),
        .in_valid(bp_in_valid), .in_data(bp_in_data), .in_ready(bp_in_ready),
        .out_valid(bp_out_valid), .out_data(bp_out_data), .out_ready(bp_out_ready),
        .count(bp_count)
    );

    function automatic fetch_data_t mk(input logic [31:0] pc, input int idx);
        fetch_data_t e;
        e.raw_instr = 32'hA000_0000 + 32'(idx);
        e.pc        = pc;
        e.valid     = 1'(idx % 2);
        return e;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        bp_flush = 1'b0; bp_in_valid = 1'b0; bp_out_ready = 1'b0; bp_in_data = '0;
        cycle(); cycle();
        reset = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (bp_count !== 3'd0) begin n_err++; $display("FAIL reset_bp_count: got %0d expected 0", bp_count); end
    endtask

    fetch_data_t fill_e [4];

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fill_e[i] = mk(32'h8000_0000 + 32'(4 * i), i);
            in_valid = 1'b1;
            in_data  = fill_e[i];
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fill_in_ready[%0d]: got %b expected 1", i, in_ready); end
            if (i == 1) begin
                n_cmp++; if (out_data !== fill_e[0]) begin n_err++; $display("FAIL fill_first_visible: got %h expected %h", out_data, fill_e[0]); end
            end
            cycle();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d expected 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready_full: got %b expected 0", in_ready); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (out_data.pc !== 32'h8000_0000) begin n_err++; $display("FAIL fill_hold_pc[%0d]: got %h expected 80000000", k, out_data.pc); end
            cycle();
        end
    endtask

    task automatic test_drain();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = (i == 0);
            in_data  = mk(32'h8000_0100, 9);
            #1;
            if (i == 0) begin
                n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL drain_full_in_ready: got %b expected 0", in_ready); end
            end
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_out_valid[%0d]: got %b expected 1", i, out_valid); end
            n_cmp++; if (out_data !== fill_e[i]) begin n_err++; $display("FAIL drain_order[%0d]: got %h expected %h", i, out_data, fill_e[i]); end
            cycle();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid_end: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL drain_out_data_end: got %h expected 0", out_data); end
    endtask

    task automatic test_empty_pop();
        out_ready = 1'b1; in_valid = 1'b0;
        cycle(); cycle();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL empty_pop_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL empty_pop_out_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        fetch_data_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = mk(32'h8000_1000 + 32'(4 * i), i);
            cycle();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = mk(32'h8000_1000 + 32'(4 * (k + 2)), k + 2);
            e = mk(32'h8000_1000 + 32'(4 * k), k);
            #1;
            n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d expected 2", k, count); end
            n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL b2b_order[%0d]: got %h expected %h", k, out_data, e); end
            cycle();
        end
        in_valid = 1'b0;
        for (int k = 10; k < 12; k++) begin
            e = mk(32'h8000_1000 + 32'(4 * k), k);
            #1;
            n_cmp++; if (out_data !== e) begin n_err++; $display("FAIL b2b_tail[%0d]: got %h expected %h", k, out_data, e); end
            cycle();
        end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_end_count: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        fetch_data_t c;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = mk(32'h8000_2000 + 32'(4 * i), i);
            cycle();
        end
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        flush = 1'b1; in_valid = 1'b1; in_data = mk(32'h8000_2FFC, 7);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL flush_out_data: got %h expected 0", out_data); end
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_post_out_valid: got %b expected 0", out_valid); end
        c = mk(32'h8000_3000, 3);
        in_valid = 1'b1; in_data = c;
        cycle();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (out_data !== c) begin n_err++; $display("FAIL flush_next_entry: got %h expected %h", out_data, c); end
        cycle();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = mk(32'h8000_4000 + 32'(4 * i), i);
            cycle();
        end
        reset = 1'b1; in_valid = 1'b1; in_data = mk(32'h8000_4FFC, 5);
        cycle();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_mid_out_data: got %h expected 0", out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_later_valid: got %b expected 0", out_valid); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = mk(32'h8000_5000, 2);
        cycle();
        reset = 1'b1; flush = 1'b1; in_valid = 1'b0;
        cycle();
        reset = 1'b0; flush = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_flush_count: got %0d expected 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_flush_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_bypass();
        fetch_data_t b;
        fetch_data_t s;
        b = mk(32'h8000_0010, 4);
        bp_in_valid = 1'b1; bp_in_data = b; bp_out_ready = 1'b1;
        #1;
        n_cmp++; if (bp_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid: got %b expected 1", bp_out_valid); end
        n_cmp++; if (bp_out_data.pc !== 32'h8000_0010) begin n_err++; $display("FAIL bp_out_pc: got %h expected 80000010", bp_out_data.pc); end
        cycle();
        bp_in_valid = 1'b0;
        #1;
        n_cmp++; if (bp_count !== 3'd0) begin n_err++; $display("FAIL bp_count: got %0d expected 0", bp_count); end
        n_cmp++; if (bp_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_valid: got %b expected 0", bp_out_valid); end
        s = mk(32'h8000_0020, 5);
        bp_in_valid = 1'b1; bp_in_data = s; bp_out_ready = 1'b0;
        cycle();
        bp_in_valid = 1'b0;
        #1;
        n_cmp++; if (bp_count !== 3'd1) begin n_err++; $display("FAIL bp_stall_count: got %0d expected 1", bp_count); end
        n_cmp++; if (bp_out_data !== s) begin n_err++; $display("FAIL bp_stall_data: got %h expected %h", bp_out_data, s); end
        bp_out_ready = 1'b1;
        cycle();
        bp_out_ready = 1'b0;
        n_cmp++; if (bp_count !== 3'd0) begin n_err++; $display("FAIL bp_drain_count: got %0d expected 0", bp_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_empty_pop();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
